// File: rtl/ddr3_arb_pkg.sv
// Shared state encoding, default widths and round-robin helper for the DDR3
// burst-port arbiter.
package ddr3_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARB   = 2'd1,
      ISSUE = 2'd2
   } arb_state_e;

   localparam int DEF_NUM_PORTS = 4;
   localparam int DEF_ADDR_W    = 28;
   localparam int DEF_LEN_W     = 10;
   localparam int DEF_TIMEOUT   = 4096;
   localparam int PORT_IDX_W    = 3;

   // Wraps with a compare so NUM_PORTS need not be a power of two.
   function automatic logic [PORT_IDX_W-1:0] rr_next(input logic [PORT_IDX_W-1:0] idx,
                                                      input int num_ports);
      return (int'(idx) >= num_ports - 1) ? 3'd0 : idx + 3'd1;
   endfunction

endpackage

// File: rtl/ddr3_rr_pick.sv
// Combinational round-robin search: first set request at or after ptr,
// wrapping to the lowest index when nothing above ptr is requesting.
module ddr3_rr_pick
   import ddr3_arb_pkg::*;
#(
   parameter int NUM_PORTS = DEF_NUM_PORTS
)(
   input  logic [NUM_PORTS-1:0]  req,
   input  logic [PORT_IDX_W-1:0] ptr,
   output logic [NUM_PORTS-1:0]  onehot,
   output logic [PORT_IDX_W-1:0] idx,
   output logic                  valid
);

   logic [NUM_PORTS-1:0] upper;

   always_comb begin
      upper = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         upper[i] = req[i] && (i >= int'(ptr));
      end
   end

   // Descending scans leave the lowest set bit standing; the second scan lets
   // requests at/after ptr override the wrapped-around winner.
   always_comb begin
      onehot = '0;
      idx    = '0;
      valid  = 1'b0;
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         if (req[i]) begin
            onehot    = '0;
            onehot[i] = 1'b1;
            idx       = PORT_IDX_W'(i);
            valid     = 1'b1;
         end
      end
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         if (upper[i]) begin
            onehot    = '0;
            onehot[i] = 1'b1;
            idx       = PORT_IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/ddr3_port_arbiter.sv
// Grants the shared DDR3 burst-command interface to one requester at a time:
// round-robin with an urgent class, plus a per-burst timeout watchdog.
module ddr3_port_arbiter
   import ddr3_arb_pkg::*;
#(
   parameter int NUM_PORTS = DEF_NUM_PORTS,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int LEN_W     = DEF_LEN_W,
   parameter int TIMEOUT   = DEF_TIMEOUT
)(
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          ddr3_init_done,
   input  logic [NUM_PORTS-1:0]          port_req,
   input  logic [NUM_PORTS-1:0]          port_urgent,
   input  logic [NUM_PORTS-1:0]          port_wr,
   input  logic [NUM_PORTS*ADDR_W-1:0]   port_addr,
   input  logic [NUM_PORTS*LEN_W-1:0]    port_len,
   output logic [NUM_PORTS-1:0]          port_grant,
   output logic [NUM_PORTS-1:0]          port_done,
   output logic [NUM_PORTS-1:0]          port_err,
   output logic                          wd_req,
   output logic [ADDR_W-1:0]             wd_addr,
   output logic [LEN_W-1:0]              wd_len,
   input  logic                          wd_finish,
   output logic                          rd_req,
   output logic [ADDR_W-1:0]             rd_addr,
   output logic [LEN_W-1:0]              rd_len,
   input  logic                          rd_finish,
   output logic                          busy,
   output logic [2:0]                    cur_port
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   arb_state_e               state_q, state_d;
   logic [NUM_PORTS-1:0]     cand, pick_onehot;
   logic [PORT_IDX_W-1:0]    pick_idx;
   logic                     pick_valid;
   logic                     sel_wr;
   logic [ADDR_W-1:0]        sel_addr;
   logic [LEN_W-1:0]         sel_len;

   logic [NUM_PORTS-1:0]     grant_q, grant_d, done_d, err_d;
   logic                     wd_req_q, wd_req_d, rd_req_q, rd_req_d;
   logic [PORT_IDX_W-1:0]    ptr_q, ptr_d, cur_q;
   logic                     wr_q;
   logic [ADDR_W-1:0]        addr_q;
   logic [LEN_W-1:0]         len_q;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic                     latch;
   logic                     dir_finish, timeout_hit;

   // Urgent requesters shadow everyone else while any of them is asking.
   assign cand = (|(port_req & port_urgent)) ? (port_req & port_urgent) : port_req;

   ddr3_rr_pick #(.NUM_PORTS(NUM_PORTS)) u_pick (
      .req    (cand),
      .ptr    (ptr_q),
      .onehot (pick_onehot),
      .idx    (pick_idx),
      .valid  (pick_valid)
   );

   always_comb begin
      sel_wr   = 1'b0;
      sel_addr = '0;
      sel_len  = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (pick_onehot[i]) begin
            sel_wr   = port_wr[i];
            sel_addr = port_addr[i*ADDR_W +: ADDR_W];
            sel_len  = port_len[i*LEN_W +: LEN_W];
         end
      end
   end

   assign dir_finish  = wr_q ? wd_finish : rd_finish;
   assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (!ddr3_init_done) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    state_d = ARB;
            ARB:     if (pick_valid && sel_len != '0) state_d = ISSUE;
            ISSUE:   if (dir_finish || timeout_hit) state_d = ARB;
            default: state_d = IDLE;
         endcase
      end
   end

   // NOTE: every signal gets a default before the case so no latch is inferred.
   always_comb begin
      grant_d  = '0;
      done_d   = '0;
      err_d    = '0;
      wd_req_d = 1'b0;
      rd_req_d = 1'b0;
      ptr_d    = ptr_q;
      cnt_d    = '0;
      latch    = 1'b0;
      if (ddr3_init_done) begin
         case (state_q)
            ARB: begin
               if (pick_valid) begin
                  latch = 1'b1;
                  if (sel_len == '0) begin
                     done_d = pick_onehot;
                     ptr_d  = rr_next(pick_idx, NUM_PORTS);
                  end else begin
                     grant_d  = pick_onehot;
                     wd_req_d = sel_wr;
                     rd_req_d = !sel_wr;
                  end
               end
            end
            ISSUE: begin
               if (dir_finish) begin
                  done_d = grant_q;
                  ptr_d  = rr_next(cur_q, NUM_PORTS);
               end else if (timeout_hit) begin
                  err_d  = grant_q;
                  ptr_d  = rr_next(cur_q, NUM_PORTS);
               end else begin
                  grant_d  = grant_q;
                  wd_req_d = wr_q;
                  rd_req_d = !wr_q;
                  cnt_d    = cnt_q + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_q   <= '0;
         port_done <= '0;
         port_err  <= '0;
         wd_req_q  <= 1'b0;
         rd_req_q  <= 1'b0;
         ptr_q     <= '0;
         cnt_q     <= '0;
         wr_q      <= 1'b0;
         addr_q    <= '0;
         len_q     <= '0;
         cur_q     <= '0;
      end else begin
         grant_q   <= grant_d;
         port_done <= done_d;
         port_err  <= err_d;
         wd_req_q  <= wd_req_d;
         rd_req_q  <= rd_req_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         if (latch) begin
            wr_q   <= sel_wr;
            addr_q <= sel_addr;
            len_q  <= sel_len;
            cur_q  <= pick_idx;
         end
      end
   end

   assign port_grant = grant_q;
   assign wd_req     = wd_req_q;
   assign rd_req     = rd_req_q;
   assign wd_addr    = addr_q;
   assign rd_addr    = addr_q;
   assign wd_len     = len_q;
   assign rd_len     = len_q;
   assign busy       = (state_q == ISSUE);
   assign cur_port   = cur_q;

endmodule

// File: tb/tb_ddr3_port_arbiter.sv
// Directed bench for ddr3_port_arbiter: stimulus queues expected grant/done/err
// events, a monitor pops and compares them as the DUT produces them.
`timescale 1ns/1ps
module tb_ddr3_port_arbiter;
   import ddr3_arb_pkg::*;

   localparam int NP  = 4;
   localparam int AW  = 28;
   localparam int LW  = 10;
   localparam int TMO = 16;

   localparam logic [AW-1:0] ADDR_TAB [NP] = '{28'h0A0_0040, 28'h0B1_2000, 28'h0C2_0100, 28'h0D3_FFC0};
   localparam logic [LW-1:0] LEN_TAB  [NP] = '{10'd16, 10'd32, 10'd8, 10'd1023};
   localparam logic [NP-1:0] WR_TAB = 4'b1010;

   logic              clk, rst_n, ddr3_init_done;
   logic [NP-1:0]     port_req, port_urgent, port_wr;
   logic [NP*AW-1:0]  port_addr;
   logic [NP*LW-1:0]  port_len;
   logic [NP-1:0]     port_grant, port_done, port_err;
   logic              wd_req, wd_finish, rd_req, rd_finish, busy;
   logic [AW-1:0]     wd_addr, rd_addr;
   logic [LW-1:0]     wd_len, rd_len;
   logic [2:0]        cur_port;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   logic busy_prev = 1'b0;

   typedef enum int {EV_GRANT, EV_DONE, EV_ERR} ev_kind_e;
   typedef struct {
      ev_kind_e kind;
      int       port;
   } ev_t;
   ev_t sb[$];

   ddr3_port_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .LEN_W(LW), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .ddr3_init_done(ddr3_init_done),
      .port_req(port_req), .port_urgent(port_urgent), .port_wr(port_wr),
      .port_addr(port_addr), .port_len(port_len),
      .port_grant(port_grant), .port_done(port_done), .port_err(port_err),
      .wd_req(wd_req), .wd_addr(wd_addr), .wd_len(wd_len), .wd_finish(wd_finish),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_finish(rd_finish),
      .busy(busy), .cur_port(cur_port)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic void expect_ev(input ev_kind_e k, input int p);
      ev_t e;
      e.kind = k;
      e.port = p;
      sb.push_back(e);
   endfunction

   task automatic mon_event(input ev_kind_e k, input logic [NP-1:0] vec);
      ev_t e;
      if (sb.size() == 0) begin
         check($sformatf("sb_unexpected_%s", k.name()), 64'(sb.size()), 64'd1);
         return;
      end
      e = sb.pop_front();
      check("ev_kind", 64'(k), 64'(e.kind));
      check("ev_vec", 64'(vec), 64'(1) << e.port);
      if (k == EV_GRANT) begin
         check("cur_port", 64'(cur_port), 64'(e.port));
         check("wd_req", 64'(wd_req), 64'(WR_TAB[e.port]));
         check("rd_req", 64'(rd_req), 64'(!WR_TAB[e.port]));
         check("cmd_addr", 64'(WR_TAB[e.port] ? wd_addr : rd_addr), 64'(ADDR_TAB[e.port]));
         check("cmd_len", 64'(WR_TAB[e.port] ? wd_len : rd_len), 64'(LEN_TAB[e.port]));
      end
   endtask

   // Monitor: sample just after each rising edge and compare against the queue.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (port_done != '0) mon_event(EV_DONE, port_done);
         if (port_err != '0)  mon_event(EV_ERR, port_err);
         if (busy && !busy_prev) mon_event(EV_GRANT, port_grant);
         busy_prev = busy;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   task automatic do_reset();
      rst_n          = 1'b0;
      ddr3_init_done = 1'b0;
      port_req       = '0;
      port_urgent    = '0;
      wd_finish      = 1'b0;
      rd_finish      = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic wait_busy(output int gcyc);
      int n;
      n = 0;
      while (!busy && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("grant_seen", 64'(busy), 64'd1);
      gcyc = cyc;
   endtask

   task automatic run_burst(input int p, input int fin_delay, input logic [NP-1:0] clr,
                            output int gcyc);
      wait_busy(gcyc);
      repeat (fin_delay) @(negedge clk);
      if (WR_TAB[p]) wd_finish = 1'b1;
      else           rd_finish = 1'b1;
      @(negedge clk);
      wd_finish = 1'b0;
      rd_finish = 1'b0;
      check("done_pulse", 64'(port_done), 64'(1) << p);
      check("busy_after_done", 64'(busy), 64'd0);
      check("req_after_done", 64'({wd_req, rd_req}), 64'd0);
      port_req = port_req & ~clr;
   endtask

   initial begin
      int g, g0, g2, prev, c0, e, n, s;

      rst_n          = 1'b1;
      ddr3_init_done = 1'b0;
      port_req       = '0;
      port_urgent    = '0;
      port_wr        = WR_TAB;
      wd_finish      = 1'b0;
      rd_finish      = 1'b0;
      for (int p = 0; p < NP; p++) begin
         port_addr[p*AW +: AW] = ADDR_TAB[p];
         port_len[p*LW +: LW]  = LEN_TAB[p];
      end
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_grant", 64'(port_grant), 64'd0);
      check("reset_done_err", 64'({port_done, port_err}), 64'd0);
      check("reset_reqs", 64'({wd_req, rd_req, busy}), 64'd0);
      check("reset_cur_port", 64'(cur_port), 64'd0);
      check("reset_addr_len", 64'({wd_addr, wd_len}), 64'd0);
      rst_n = 1'b1;

      // Init gating: no grant until calibration completes.
      port_req = 4'b0001;
      repeat (4) @(negedge clk);
      check("no_grant_before_init", 64'({port_grant, busy, rd_req}), 64'd0);
      expect_ev(EV_GRANT, 0);
      expect_ev(EV_DONE, 0);
      c0 = cyc;
      ddr3_init_done = 1'b1;
      run_burst(0, 1, 4'b0001, g);
      check("init_grant_latency", 64'(g - c0), 64'd2);

      // Round-robin fairness with all ports requesting.
      do_reset();
      for (int k = 0; k < 8; k++) begin
         expect_ev(EV_GRANT, k % 4);
         expect_ev(EV_DONE, k % 4);
      end
      port_req = 4'hF;
      ddr3_init_done = 1'b1;
      prev = 0;
      for (int k = 0; k < 8; k++) begin
         run_burst(k % 4, 1, (k == 7) ? 4'hF : 4'h0, g);
         if (k > 0) check("rr_period", 64'(g - prev), 64'd3);
         prev = g;
      end

      // Urgent class beats pointer order; finish in the first ISSUE cycle.
      do_reset();
      expect_ev(EV_GRANT, 2);
      expect_ev(EV_DONE, 2);
      expect_ev(EV_GRANT, 0);
      expect_ev(EV_DONE, 0);
      port_urgent = 4'b0100;
      port_req    = 4'b0101;
      ddr3_init_done = 1'b1;
      run_burst(2, 0, 4'b0100, g2);
      port_urgent = '0;
      run_burst(0, 0, 4'b0001, g0);
      check("urgent_then_rr_gap", 64'(g0 - g2), 64'd2);

      // Direction filtering on a write burst; inputs are don't-care after grant.
      expect_ev(EV_GRANT, 1);
      expect_ev(EV_DONE, 1);
      port_req = 4'b0010;
      wait_busy(g);
      port_addr[1*AW +: AW] = 28'hFFF_FFFF;
      port_len[1*LW +: LW]  = 10'd5;
      rd_finish = 1'b1;
      @(negedge clk);
      rd_finish = 1'b0;
      check("rd_finish_ignored", 64'({busy, wd_req, rd_req}), 64'b110);
      check("rd_finish_no_done", 64'(port_done), 64'd0);
      check("addr_held", 64'(wd_addr), 64'(ADDR_TAB[1]));
      check("len_held", 64'(wd_len), 64'(LEN_TAB[1]));
      port_addr[1*AW +: AW] = ADDR_TAB[1];
      port_len[1*LW +: LW]  = LEN_TAB[1];
      wd_finish = 1'b1;
      rd_finish = 1'b1;
      @(negedge clk);
      wd_finish = 1'b0;
      rd_finish = 1'b0;
      check("wd_finish_done", 64'(port_done), 64'b0010);
      check("wd_req_dropped", 64'({wd_req, busy}), 64'd0);
      port_req = '0;

      // Timeout on port 3, then port 0 is served.
      expect_ev(EV_GRANT, 3);
      expect_ev(EV_ERR, 3);
      expect_ev(EV_GRANT, 0);
      expect_ev(EV_DONE, 0);
      port_req = 4'b1001;
      wait_busy(g);
      n = 0;
      while (port_err == '0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("err_pulse", 64'(port_err), 64'b1000);
      check("err_latency", 64'(cyc - g), 64'(TMO));
      check("err_no_done", 64'(port_done), 64'd0);
      check("err_req_dropped", 64'({wd_req, rd_req, busy}), 64'd0);
      e = cyc;
      port_req = 4'b0001;
      run_burst(0, 0, 4'b0001, g0);
      check("grant_after_err", 64'(g0 - e), 64'd1);

      // Zero-length burst completes without a command.
      expect_ev(EV_DONE, 2);
      port_len[2*LW +: LW] = '0;
      port_req = 4'b0100;
      s = cyc;
      @(negedge clk);
      check("zero_len_done", 64'(port_done), 64'b0100);
      check("zero_len_no_cmd", 64'({wd_req, rd_req, busy, port_grant}), 64'd0);
      check("zero_len_latency", 64'(cyc - s), 64'd1);
      port_req = '0;
      port_len[2*LW +: LW] = LEN_TAB[2];
      repeat (3) @(negedge clk);
      check("zero_len_stays_idle", 64'(busy), 64'd0);

      // Losing calibration mid-burst: silent drop, then re-grant from IDLE.
      expect_ev(EV_GRANT, 0);
      port_req = 4'b0001;
      wait_busy(g);
      ddr3_init_done = 1'b0;
      @(negedge clk);
      check("init_drop_outputs", 64'({port_grant, busy, rd_req, wd_req}), 64'd0);
      check("init_drop_no_pulse", 64'({port_done, port_err}), 64'd0);
      expect_ev(EV_GRANT, 0);
      ddr3_init_done = 1'b1;
      c0 = cyc;
      wait_busy(g);
      check("regrant_latency", 64'(g - c0), 64'd2);

      // Asynchronous reset in the middle of a burst.
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_outputs", 64'({port_grant, busy, rd_req, wd_req}), 64'd0);
      check("rst_mid_addr", 64'(rd_addr), 64'd0);
      check("rst_mid_len", 64'(rd_len), 64'd0);
      @(negedge clk);
      expect_ev(EV_GRANT, 0);
      expect_ev(EV_DONE, 0);
      rst_n = 1'b1;
      c0 = cyc;
      run_burst(0, 0, 4'b0001, g);
      check("post_reset_latency", 64'(g - c0), 64'd2);

      repeat (3) @(negedge clk);
      check("sb_drained", 64'(sb.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
